hazard_branch_ctrl: RTL and testbench

HAZARD_BRANCH_CTRL -- requirements
Module: hazard_branch_ctrl

---
 rtl/hazard_branch_ctrl_if.sv | 54 +++++
 rtl/hazard_branch_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_branch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_branch_ctrl_if.sv
// Bundle between the ID/EX pipeline stages and the hazard/branch controller.
// Counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_branch_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_pc;
  logic [11:0] ex_imm;
  logic        zero_flag;

  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        flush_ifid;
  logic        flush_idex;
  logic        pc_sel;
  logic [63:0] branch_target;
  logic [1:0]  state;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] redirect_count;

  modport master (
    output id_rs1, id_rs2, id_valid, ex_rd, ex_mem_read, ex_valid,
           ex_opcode, ex_funct3, ex_pc, ex_imm, zero_flag,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex,
           pc_sel, branch_target, state, stall_count, redirect_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_valid, ex_rd, ex_mem_read, ex_valid,
           ex_opcode, ex_funct3, ex_pc, ex_imm, zero_flag,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex,
           pc_sel, branch_target, state, stall_count, redirect_count
  );
`else
  modport master (
    output id_rs1, id_rs2, id_valid, ex_rd, ex_mem_read, ex_valid,
           ex_opcode, ex_funct3, ex_pc, ex_imm, zero_flag,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex,
           pc_sel, branch_target, state
  );
  modport slave (
    input  id_rs1, id_rs2, id_valid, ex_rd, ex_mem_read, ex_valid,
           ex_opcode, ex_funct3, ex_pc, ex_imm, zero_flag,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex,
           pc_sel, branch_target, state
  );
`endif
endinterface

// File: rtl/hazard_branch_ctrl.sv
// Load-use stall and taken-branch redirect controller; all outputs registered, one cycle after the sampled condition.
// Optional entry counters enabled by defining HAZARD_STATS_EN.
module hazard_branch_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  hazard_branch_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_e      state_q, state_d;
  logic        pc_write_q, ifid_write_q, idex_bubble_q;
  logic        flush_ifid_q, flush_idex_q, pc_sel_q;
  logic [63:0] branch_target_q, target_d;
  logic        br_taken, load_use;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, redirect_cnt_q;
`endif

  always_comb begin
    br_taken = hz.ex_valid && (hz.ex_opcode == OPC_BRANCH) &&
               (((hz.ex_funct3 == 3'b000) &&  hz.zero_flag) ||
                ((hz.ex_funct3 == 3'b001) && !hz.zero_flag));
    load_use = hz.id_valid && hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
    // B-type offset is in halfwords; the add wraps modulo 2^64
    target_d = hz.ex_pc + {{51{hz.ex_imm[11]}}, hz.ex_imm, 1'b0};
    state_d  = RUN;
    if (state_q == RUN) begin
      if (br_taken)      state_d = REDIRECT;
      else if (load_use) state_d = STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      pc_write_q      <= 1'b1;
      ifid_write_q    <= 1'b1;
      idex_bubble_q   <= 1'b0;
      flush_ifid_q    <= 1'b0;
      flush_idex_q    <= 1'b0;
      pc_sel_q        <= 1'b0;
      branch_target_q <= 64'd0;
`ifdef HAZARD_STATS_EN
      stall_cnt_q     <= 32'd0;
      redirect_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      case (state_d)
        STALL: begin
          pc_write_q    <= 1'b0;
          ifid_write_q  <= 1'b0;
          idex_bubble_q <= 1'b1;
          flush_ifid_q  <= 1'b0;
          flush_idex_q  <= 1'b0;
          pc_sel_q      <= 1'b0;
`ifdef HAZARD_STATS_EN
          if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
        end
        REDIRECT: begin
          pc_write_q      <= 1'b1;
          ifid_write_q    <= 1'b1;
          idex_bubble_q   <= 1'b0;
          flush_ifid_q    <= 1'b1;
          flush_idex_q    <= 1'b1;
          pc_sel_q        <= 1'b1;
          branch_target_q <= target_d;
`ifdef HAZARD_STATS_EN
          if (redirect_cnt_q != 32'hFFFF_FFFF) redirect_cnt_q <= redirect_cnt_q + 32'd1;
`endif
        end
        default: begin
          pc_write_q    <= 1'b1;
          ifid_write_q  <= 1'b1;
          idex_bubble_q <= 1'b0;
          flush_ifid_q  <= 1'b0;
          flush_idex_q  <= 1'b0;
          pc_sel_q      <= 1'b0;
        end
      endcase
    end
  end

  assign hz.pc_write      = pc_write_q;
  assign hz.ifid_write    = ifid_write_q;
  assign hz.idex_bubble   = idex_bubble_q;
  assign hz.flush_ifid    = flush_ifid_q;
  assign hz.flush_idex    = flush_idex_q;
  assign hz.pc_sel        = pc_sel_q;
  assign hz.branch_target = branch_target_q;
  assign hz.state         = state_q;
`ifdef HAZARD_STATS_EN
  assign hz.stall_count    = stall_cnt_q;
  assign hz.redirect_count = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_branch_ctrl.sv
// Directed bench for hazard_branch_ctrl: reset, branch redirect, load-use stall, priority, reset abort.
// Counter checks are compiled in when HAZARD_STATS_EN is defined.
module tb_hazard_branch_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hazard_branch_ctrl_if hz ();

  hazard_branch_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic pcw,
                          input logic ifw, input logic bub, input logic fif,
                          input logic fie, input logic sel, input logic [63:0] tgt);
    chk({tag, ".state"},         {62'd0, hz.state}, {62'd0, st});
    chk({tag, ".pc_write"},      {63'd0, hz.pc_write}, {63'd0, pcw});
    chk({tag, ".ifid_write"},    {63'd0, hz.ifid_write}, {63'd0, ifw});
    chk({tag, ".idex_bubble"},   {63'd0, hz.idex_bubble}, {63'd0, bub});
    chk({tag, ".flush_ifid"},    {63'd0, hz.flush_ifid}, {63'd0, fif});
    chk({tag, ".flush_idex"},    {63'd0, hz.flush_idex}, {63'd0, fie});
    chk({tag, ".pc_sel"},        {63'd0, hz.pc_sel}, {63'd0, sel});
    chk({tag, ".branch_target"}, hz.branch_target, tgt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs1 = 5'd0;  hz.id_rs2 = 5'd0;  hz.id_valid = 1'b0;
    hz.ex_rd = 5'd0;   hz.ex_mem_read = 1'b0; hz.ex_valid = 1'b0;
    hz.ex_opcode = 7'd0; hz.ex_funct3 = 3'd0; hz.ex_pc = 64'd0;
    hz.ex_imm = 12'd0; hz.zero_flag = 1'b0;
  endtask

  task automatic set_branch(input logic [63:0] pc, input logic [11:0] imm,
                            input logic [2:0] f3, input logic z);
    hz.ex_valid = 1'b1; hz.ex_opcode = 7'b1100011;
    hz.ex_pc = pc; hz.ex_imm = imm; hz.ex_funct3 = f3; hz.zero_flag = z;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    hz.ex_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = rd;
    hz.id_valid = 1'b1; hz.id_rs1 = rs1; hz.id_rs2 = rs2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk_outs("reset", 2'd0, 1, 1, 0, 0, 0, 0, 64'd0);
    rst = 1'b0;
    step();
    chk_outs("idle", 2'd0, 1, 1, 0, 0, 0, 0, 64'd0);

    // BEQ taken; inputs left asserted during REDIRECT must be ignored
    set_branch(64'h1000, 12'h008, 3'b000, 1'b1);
    step();
    chk_outs("beq_taken", 2'd2, 1, 1, 0, 1, 1, 1, 64'h1010);
    step();
    chk_outs("beq_after", 2'd0, 1, 1, 0, 0, 0, 0, 64'h1010);
    idle_inputs();
    step();
    chk_outs("beq_idle", 2'd0, 1, 1, 0, 0, 0, 0, 64'h1010);

    set_branch(64'h1000, 12'hFF8, 3'b000, 1'b1);
    step();
    chk_outs("beq_neg", 2'd2, 1, 1, 0, 1, 1, 1, 64'h0FF0);
    idle_inputs();
    step();

    set_branch(64'h3000, 12'h010, 3'b001, 1'b1);
    step();
    chk_outs("bne_not_taken", 2'd0, 1, 1, 0, 0, 0, 0, 64'h0FF0);

    set_branch(64'h2000, 12'h004, 3'b001, 1'b0);
    step();
    chk_outs("bne_taken", 2'd2, 1, 1, 0, 1, 1, 1, 64'h2008);
    idle_inputs();
    step();

    set_branch(64'h4000, 12'h004, 3'b100, 1'b1);
    step();
    chk_outs("other_funct3", 2'd0, 1, 1, 0, 0, 0, 0, 64'h2008);

    set_branch(64'h4000, 12'h004, 3'b000, 1'b1);
    hz.ex_valid = 1'b0;
    step();
    chk_outs("branch_invalid", 2'd0, 1, 1, 0, 0, 0, 0, 64'h2008);

    set_branch(64'hFFFF_FFFF_FFFF_FFFC, 12'h004, 3'b000, 1'b1);
    step();
    chk_outs("target_wrap", 2'd2, 1, 1, 0, 1, 1, 1, 64'h4);
    idle_inputs();
    step();

    // Load-use on rs2; held inputs must not extend the stall
    hz.ex_opcode = 7'b0000011;
    set_load(5'd5, 5'd0, 5'd5);
    step();
    chk_outs("load_use_rs2", 2'd1, 0, 0, 1, 0, 0, 0, 64'h4);
    step();
    chk_outs("stall_one_cycle", 2'd0, 1, 1, 0, 0, 0, 0, 64'h4);
    idle_inputs();
    step();

    hz.ex_opcode = 7'b0000011;
    set_load(5'd0, 5'd0, 5'd0);
    step();
    chk_outs("load_rd0", 2'd0, 1, 1, 0, 0, 0, 0, 64'h4);

    set_load(5'd7, 5'd7, 5'd1);
    hz.id_valid = 1'b0;
    step();
    chk_outs("load_id_invalid", 2'd0, 1, 1, 0, 0, 0, 0, 64'h4);

    set_load(5'd7, 5'd7, 5'd1);
    step();
    chk_outs("load_use_rs1", 2'd1, 0, 0, 1, 0, 0, 0, 64'h4);
    idle_inputs();
    step();

    set_branch(64'h1000, 12'h008, 3'b000, 1'b1);
    set_load(5'd5, 5'd5, 5'd0);
    step();
    chk_outs("branch_prio", 2'd2, 1, 1, 0, 1, 1, 1, 64'h1010);
    idle_inputs();
    step();
    chk_outs("branch_prio_after", 2'd0, 1, 1, 0, 0, 0, 0, 64'h1010);

    hz.ex_opcode = 7'b0000011;
    set_load(5'd3, 5'd3, 5'd0);
    step();
    chk_outs("pre_rst_stall", 2'd1, 0, 0, 1, 0, 0, 0, 64'h1010);
    idle_inputs();
    rst = 1'b1;
    step();
    chk_outs("rst_in_stall", 2'd0, 1, 1, 0, 0, 0, 0, 64'd0);
    rst = 1'b0;

    set_branch(64'h1000, 12'h008, 3'b000, 1'b1);
    step();
    chk_outs("pre_rst_redirect", 2'd2, 1, 1, 0, 1, 1, 1, 64'h1010);
    idle_inputs();
    rst = 1'b1;
    step();
    chk_outs("rst_in_redirect", 2'd0, 1, 1, 0, 0, 0, 0, 64'd0);
    rst = 1'b0;
    step();
    chk_outs("post_rst", 2'd0, 1, 1, 0, 0, 0, 0, 64'd0);

`ifdef HAZARD_STATS_EN
    chk("stall_count_rst", {32'd0, hz.stall_count}, 64'd0);
    chk("redirect_count_rst", {32'd0, hz.redirect_count}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      hz.ex_opcode = 7'b0000011;
      set_load(5'd9, 5'd0, 5'd9);
      step();
      idle_inputs();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      set_branch(64'h8000, 12'h002, 3'b000, 1'b1);
      step();
      idle_inputs();
      step();
    end
    chk("stall_count", {32'd0, hz.stall_count}, 64'd3);
    chk("redirect_count", {32'd0, hz.redirect_count}, 64'd2);
    chk_outs("stats_end", 2'd0, 1, 1, 0, 0, 0, 0, 64'h8004);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
